// File: rtl/dac1k_if_tx.sv
// Transmit-side LVDS DDR interface: sample-pair FIFO, training/run sequencer,
// SAME_EDGE DDR output stage with differential data pins and a forwarded clock.
module dac1k_if_tx #(
   parameter int unsigned TRAIN_CYCLES = 64,
   parameter logic [7:0]  TRAIN_A      = 8'hAA,
   parameter logic [7:0]  TRAIN_B      = 8'h55,
   parameter logic [7:0]  IDLE_WORD    = 8'h00
) (
   input  logic        dclk,
   input  logic        reset_n,
   input  logic        train_req,
   input  logic [7:0]  din_1,
   input  logic [7:0]  din_2,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [7:0]  Dpin_P,
   output logic [7:0]  Dpin_N,
   output logic        DCO_P,
   output logic        DCO_N,
   output logic [1:0]  state,
   output logic        train_done,
   output logic [15:0] underflow_cnt
);

   localparam logic [1:0]  ST_RESET   = 2'b00;
   localparam logic [1:0]  ST_TRAIN   = 2'b01;
   localparam logic [1:0]  ST_RUN     = 2'b10;
   localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 32'd1);

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [15:0] train_cnt_r;
   logic [15:0] fifo_mem_r [4];
   logic [1:0]  wr_ptr_r;
   logic [1:0]  rd_ptr_r;
   logic [2:0]  fifo_cnt_r;
   logic [7:0]  launch1_r;
   logic [7:0]  launch2_r;
   logic [7:0]  oddr_d1_r;
   logic [7:0]  oddr_d2_r;
   logic        dco_d1_r;
   logic        dco_d2_r;
   logic        train_done_r;
   logic [15:0] underflow_cnt_r;

   logic        run_s;
   logic        ready_s;
   logic        wr_en_s;
   logic        rd_en_s;
   logic        flush_s;
   logic        udf_s;
   logic        train_end_s;

   // State register.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RESET: state_nxt_s = ST_TRAIN;
         ST_TRAIN: begin
            if (train_end_s) state_nxt_s = ST_RUN;
            else             state_nxt_s = ST_TRAIN;
         end
         ST_RUN: begin
            if (train_req) state_nxt_s = ST_TRAIN;
            else           state_nxt_s = ST_RUN;
         end
         default: state_nxt_s = ST_RESET;
      endcase
   end

   // Handshake, FIFO control and sequencer decode.
   always_comb begin
      run_s       = (state_r == ST_RUN);
      ready_s     = run_s && (fifo_cnt_r != 3'd4) && !train_req;
      wr_en_s     = din_valid && ready_s;
      flush_s     = run_s && train_req;
      rd_en_s     = run_s && !train_req && (fifo_cnt_r != 3'd0);
      udf_s       = run_s && !train_req && (fifo_cnt_r == 3'd0);
      train_end_s = (state_r == ST_TRAIN) && (train_cnt_r == TRAIN_LAST);
   end

   assign din_ready = ready_s;

   // Training burst length counter; restarts from zero on every entry to TRAIN.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         train_cnt_r <= 16'd0;
      end else if ((state_r == ST_TRAIN) && !train_end_s) begin
         train_cnt_r <= train_cnt_r + 16'd1;
      end else begin
         train_cnt_r <= 16'd0;
      end
   end

   // FIFO storage and pointers; an empty FIFO never pops, so a word written
   // into an empty FIFO is first visible to the drain on the following edge.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) fifo_mem_r[i] <= 16'd0;
         wr_ptr_r   <= 2'd0;
         rd_ptr_r   <= 2'd0;
         fifo_cnt_r <= 3'd0;
      end else if (flush_s) begin
         wr_ptr_r   <= 2'd0;
         rd_ptr_r   <= 2'd0;
         fifo_cnt_r <= 3'd0;
      end else begin
         if (wr_en_s) begin
            fifo_mem_r[wr_ptr_r] <= {din_2, din_1};
            wr_ptr_r             <= wr_ptr_r + 2'd1;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         fifo_cnt_r <= fifo_cnt_r + {2'b00, wr_en_s} - {2'b00, rd_en_s};
      end
   end

   // Launch registers; the flush edge already sends training so that buffered
   // words are never launched.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         launch1_r <= 8'h00;
         launch2_r <= 8'h00;
      end else begin
         case (state_r)
            ST_TRAIN: begin
               launch1_r <= TRAIN_A;
               launch2_r <= TRAIN_B;
            end
            ST_RUN: begin
               if (flush_s) begin
                  launch1_r <= TRAIN_A;
                  launch2_r <= TRAIN_B;
               end else if (rd_en_s) begin
                  launch1_r <= fifo_mem_r[rd_ptr_r][7:0];
                  launch2_r <= fifo_mem_r[rd_ptr_r][15:8];
               end else begin
                  launch1_r <= IDLE_WORD;
                  launch2_r <= IDLE_WORD;
               end
            end
            default: begin
               launch1_r <= 8'h00;
               launch2_r <= 8'h00;
            end
         endcase
      end
   end

   // Status outputs: train_done coincides with the first RUN cycle.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         train_done_r    <= 1'b0;
         underflow_cnt_r <= 16'd0;
      end else begin
         train_done_r <= train_end_s;
         if (udf_s && (underflow_cnt_r != 16'hFFFF)) begin
            underflow_cnt_r <= underflow_cnt_r + 16'd1;
         end else begin
            underflow_cnt_r <= underflow_cnt_r;
         end
      end
   end

   // ODDR capture stage (SAME_EDGE): both slots sampled on the rising edge.
   always_ff @(posedge dclk or negedge reset_n) begin
      if (!reset_n) begin
         oddr_d1_r <= 8'h00;
         oddr_d2_r <= 8'h00;
         dco_d1_r  <= 1'b0;
         dco_d2_r  <= 1'b0;
      end else begin
         oddr_d1_r <= launch1_r;
         oddr_d2_r <= launch2_r;
         dco_d1_r  <= 1'b1;
         dco_d2_r  <= 1'b0;
      end
   end

   // DDR pad mux and LVDS_25 differential buffers.
   assign Dpin_P = dclk ? oddr_d1_r : oddr_d2_r;
   assign Dpin_N = ~Dpin_P;
   assign DCO_P  = dclk ? dco_d1_r : dco_d2_r;
   assign DCO_N  = ~DCO_P;

   assign state         = state_r;
   assign train_done    = train_done_r;
   assign underflow_cnt = underflow_cnt_r;

endmodule
